// File: rtl/dcache_dm_wt_if.sv
// Core-side and memory-side signals of the write-through data cache.
// The slave modport is the cache's view, and the master modport is the core/memory side.
interface dcache_dm_wt_if #(
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           data_in;
    logic                  write_enable;
    logic [31:0]           data_out;
    logic                  data_out_valid;
    logic                  busy;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  address, data_in, write_enable, mem_rdata, mem_ready,
        output data_out, data_out_valid, busy, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output address, data_in, write_enable, mem_rdata, mem_ready,
        input  data_out, data_out_valid, busy, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, write-allocate data cache with one 32-bit word per line.
// Reads hit combinationally. Misses and all writes go to a request/ready memory port.
module dcache_dm_wt #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINES_LOG2 = 6
) (
    input  logic          clk,
    input  logic          rst,
    dcache_dm_wt_if.slave bus
);
    localparam int unsigned Lines = 1 << LINES_LOG2;
    localparam int unsigned TagW  = ADDR_WIDTH - LINES_LOG2 - 2;

    typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

    state_e                state_q, state_d;
    logic [Lines-1:0]      valid_q, valid_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic [31:0]           data_arr [Lines];
    logic [TagW-1:0]       tag_arr  [Lines];

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [LINES_LOG2-1:0] idx, fill_idx, arr_idx;
    logic [TagW-1:0]       tag, fill_tag, arr_tag;
    logic [31:0]           arr_wdata;
    logic                  arr_we;
    logic                  hit;

    assign word_addr = bus.address & ~ADDR_WIDTH'(3);
    assign idx       = bus.address[LINES_LOG2+1:2];
    assign tag       = bus.address[ADDR_WIDTH-1:LINES_LOG2+2];
    // The outstanding fill's line is recovered from the latched request address.
    assign fill_idx  = mem_addr_q[LINES_LOG2+1:2];
    assign fill_tag  = mem_addr_q[ADDR_WIDTH-1:LINES_LOG2+2];

    assign hit = (state_q == StIdle) && valid_q[idx] && (tag_arr[idx] == tag) &&
                 !bus.write_enable;

    assign bus.data_out_valid = hit;
    assign bus.data_out       = hit ? data_arr[idx] : 32'h0;
    assign bus.busy           = (state_q != StIdle);
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        arr_we      = 1'b0;
        arr_idx     = idx;
        arr_tag     = tag;
        arr_wdata   = bus.data_in;

        unique case (state_q)
            StIdle: begin
                if (bus.write_enable) begin
                    arr_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    mem_addr_d   = word_addr;
                    mem_wdata_d  = bus.data_in;
                    mem_we_d     = 1'b1;
                    mem_req_d    = 1'b1;
                    state_d      = StWrite;
                end else if (!hit) begin
                    mem_addr_d = word_addr;
                    mem_we_d   = 1'b0;
                    mem_req_d  = 1'b1;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (bus.mem_ready && mem_req_q) begin
                    arr_we            = 1'b1;
                    arr_idx           = fill_idx;
                    arr_tag           = fill_tag;
                    arr_wdata         = bus.mem_rdata;
                    valid_d[fill_idx] = 1'b1;
                    mem_req_d         = 1'b0;
                    state_d           = StIdle;
                end
            end
            StWrite: begin
                if (bus.mem_ready && mem_req_q) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Data and tag arrays are not reset. The valid vector alone marks them stale.
    always_ff @(posedge clk) begin
        if (arr_we && !rst) begin
            data_arr[arr_idx] <= arr_wdata;
            tag_arr[arr_idx]  <= arr_tag;
        end
    end
endmodule
